alu_ctrl_seq: RTL and testbench

Registered, handshaked ALU control stage for the execute pipeline. It accepts `{ALUOP, opcode}` from the ID/EX boundary, decodes it to a 4-bit ALU operation and presents the result with valid/ready flow control. Multi-cycle operations (MUL) are held for a parametrised latency before being presented. It replaces the purely combinational ALU control path and allows execute stalls without losing the decoded operation.

---
 rtl/alu_ctrl_pkg.sv | 37 +++
 rtl/alu_ctrl_seq_if.sv | 26 ++
 rtl/alu_ctrl_decode.sv | 45 ++++
 rtl/alu_ctrl_seq.sv | 91 +++++++++
 tb/tb_alu_ctrl_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control stage: opcode patterns, ALU operation
// codes, ALUOp classes and the stage FSM states.
package alu_ctrl_pkg;

   localparam logic [10:0] OPC_ADD     = 11'b10001011000;
   localparam logic [10:0] OPC_SUB     = 11'b11001011000;
   localparam logic [10:0] OPC_AND     = 11'b10001010000;
   localparam logic [10:0] OPC_ORR     = 11'b10101010000;
   localparam logic [10:0] OPC_LSL     = 11'b11010011011;
   localparam logic [10:0] OPC_LSR     = 11'b11010011010;
   localparam logic [10:0] OPC_B_MASK  = 11'b11111100000;
   localparam logic [10:0] OPC_B_MATCH = 11'b00010100000;
   localparam logic [10:0] OPC_MUL     = 11'b10011011000;

   localparam logic [3:0] ALU_AND    = 4'b0000;
   localparam logic [3:0] ALU_ORR    = 4'b0001;
   localparam logic [3:0] ALU_ADD    = 4'b0010;
   localparam logic [3:0] ALU_LSL    = 4'b0011;
   localparam logic [3:0] ALU_SUB    = 4'b0110;
   localparam logic [3:0] ALU_PASS_B = 4'b0111;
   localparam logic [3:0] ALU_MUL    = 4'b1000;
   localparam logic [3:0] ALU_BR     = 4'b1111;

   typedef enum logic [1:0] {
      ALUOP_D   = 2'b00,
      ALUOP_B   = 2'b01,
      ALUOP_R   = 2'b10,
      ALUOP_RSV = 2'b11
   } aluop_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_VALID = 2'b10
   } state_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Handshake bus of the ALU control stage; master = ID/EX + execute side,
// slave = the alu_ctrl_seq stage.
interface alu_ctrl_seq_if #(
   parameter int unsigned OP_W = 4
);
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      alu_op;
   logic [10:0]     opcode;
   logic            out_valid;
   logic            out_ready;
   logic [OP_W-1:0] operation;
   logic            multicycle;
   logic            illegal;
   logic            busy;

   modport master (
      output in_valid, alu_op, opcode, out_ready,
      input  in_ready, out_valid, operation, multicycle, illegal, busy
   );

   modport slave (
      input  in_valid, alu_op, opcode, out_ready,
      output in_ready, out_valid, operation, multicycle, illegal, busy
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational {alu_op, opcode} decode to ALU operation and flags.
// MUL is recognised only when ALU_CTRL_MUL_EN is defined.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
(
   input  logic [1:0]  alu_op,
   input  logic [10:0] opcode,
   output logic [3:0]  operation,
   output logic        multicycle,
   output logic        illegal
);

   always_comb begin
      operation  = '0;
      multicycle = 1'b0;
      illegal    = 1'b0;
      case (aluop_e'(alu_op))
         ALUOP_D: operation = ALU_ADD;
         ALUOP_B: operation = ALU_PASS_B;
         ALUOP_R: begin
            if ((opcode & OPC_B_MASK) == OPC_B_MATCH) begin
               operation = ALU_BR;
            end else begin
               case (opcode)
                  OPC_ADD: operation = ALU_ADD;
                  OPC_SUB: operation = ALU_SUB;
                  OPC_AND: operation = ALU_AND;
                  OPC_ORR: operation = ALU_ORR;
                  OPC_LSL: operation = ALU_LSL;
                  OPC_LSR: operation = ALU_PASS_B;
`ifdef ALU_CTRL_MUL_EN
                  OPC_MUL: begin
                     operation  = ALU_MUL;
                     multicycle = 1'b1;
                  end
`endif
                  default: illegal = 1'b1;
               endcase
            end
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control stage with optional multi-cycle MUL path.
// Optional feature macro: ALU_CTRL_MUL_EN (MUL decode + BUSY latency counter).
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned OP_W    = 4
) (
   input logic           clk,
   input logic           rst_n,
   alu_ctrl_seq_if.slave bus
);

   localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);
   localparam bit         USE_BUSY = (MUL_LAT > 1);

   logic [3:0]      dec_op;
   logic            dec_mc;
   logic            dec_ill;
   state_e          state_q, state_d;
   state_e          state_acc;
   logic [3:0]      cnt_q, cnt_d;
   logic [OP_W-1:0] op_q;
   logic            mc_q, ill_q;
   logic            in_ready;
   logic            accept;

   alu_ctrl_decode u_decode (
      .alu_op     (bus.alu_op),
      .opcode     (bus.opcode),
      .operation  (dec_op),
      .multicycle (dec_mc),
      .illegal    (dec_ill)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      state_acc = (dec_mc && USE_BUSY) ? ST_BUSY : ST_VALID;
      case (state_q)
         ST_EMPTY: in_ready = 1'b1;
         ST_VALID: in_ready = bus.out_ready;
         default:  in_ready = 1'b0;
      endcase
      accept = bus.in_valid && in_ready;

      case (state_q)
         ST_EMPTY: if (accept) state_d = state_acc;
         ST_VALID: if (bus.out_ready) state_d = accept ? state_acc : ST_EMPTY;
         ST_BUSY: begin
            // Leave on the cycle the count reaches 0, so BUSY lasts MUL_LAT-1 cycles.
            if (cnt_q <= 4'd1) state_d = ST_VALID;
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
         end
         default: state_d = ST_EMPTY;
      endcase

      if (accept && state_acc == ST_BUSY) cnt_d = CNT_INIT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
         op_q    <= '0;
         mc_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            op_q  <= OP_W'(dec_op);
            mc_q  <= dec_mc;
            ill_q <= dec_ill;
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = (state_q == ST_VALID);
   assign bus.operation  = op_q;
   assign bus.multicycle = mc_q;
   assign bus.illegal    = ill_q;
`ifdef ALU_CTRL_MUL_EN
   assign bus.busy       = (state_q == ST_BUSY);
`else
   assign bus.busy       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed, table-driven bench for alu_ctrl_seq (MUL_LAT = 3, OP_W = 4).
// Follows ALU_CTRL_MUL_EN to pick the expected MUL behaviour.
module tb_alu_ctrl_seq;

   typedef struct packed {
      logic [1:0]  aop;
      logic [10:0] opc;
      logic [3:0]  eop;
      logic        eill;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_mis;
   vec_t tbl [11];

   alu_ctrl_seq_if #(.OP_W(4)) bus ();

   alu_ctrl_seq #(.MUL_LAT(3), .OP_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] aop, input logic [10:0] opc);
      bus.in_valid = v;
      bus.alu_op   = aop;
      bus.opcode   = opc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_mis = 0;
      tbl[0]  = '{2'b10, 11'b11001011000, 4'b0110, 1'b0}; // SUB
      tbl[1]  = '{2'b10, 11'b10001010000, 4'b0000, 1'b0}; // AND
      tbl[2]  = '{2'b10, 11'b10101010000, 4'b0001, 1'b0}; // ORR
      tbl[3]  = '{2'b10, 11'b11010011011, 4'b0011, 1'b0}; // LSL
      tbl[4]  = '{2'b10, 11'b11010011010, 4'b0111, 1'b0}; // LSR
      tbl[5]  = '{2'b10, 11'b00010111111, 4'b1111, 1'b0}; // B
      tbl[6]  = '{2'b00, 11'b11111111111, 4'b0010, 1'b0}; // D-type
      tbl[7]  = '{2'b01, 11'b01010101010, 4'b0111, 1'b0}; // B-type
      tbl[8]  = '{2'b11, 11'b10001011000, 4'b0000, 1'b1}; // reserved
      tbl[9]  = '{2'b10, 11'b11111111111, 4'b0000, 1'b1}; // unmatched R
      tbl[10] = '{2'b10, 11'b10101010000, 4'b0001, 1'b0}; // ORR

      // Reset with in_valid asserted
      rst_n = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b1, 2'b10, 11'b10001011000);
      repeat (2) step();
      chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
      chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
      chk("rst_busy",       32'(bus.busy),       32'd0);
      chk("rst_operation",  32'(bus.operation),  32'd0);
      chk("rst_multicycle", 32'(bus.multicycle), 32'd0);
      chk("rst_illegal",    32'(bus.illegal),    32'd0);
      rst_n = 1'b1;
      #1;
      chk("add_pre_valid", 32'(bus.out_valid), 32'd0);
      step();
      chk("add_valid", 32'(bus.out_valid), 32'd1);
      chk("add_op",    32'(bus.operation), 32'h2);

      // Back-to-back stream, out_ready high
      for (int unsigned i = 0; i < 11; i++) begin
         drive(1'b1, tbl[i].aop, tbl[i].opc);
         chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
         step();
         chk($sformatf("vec%0d_valid", i),   32'(bus.out_valid),  32'd1);
         chk($sformatf("vec%0d_op", i),      32'(bus.operation),  32'(tbl[i].eop));
         chk($sformatf("vec%0d_illegal", i), 32'(bus.illegal),    32'(tbl[i].eill));
         chk($sformatf("vec%0d_mc", i),      32'(bus.multicycle), 32'd0);
      end

      // Backpressure: ORR held while ADD waits
      bus.out_ready = 1'b0;
      drive(1'b1, 2'b10, 11'b10001011000);
      for (int unsigned i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready),  32'd0);
         chk($sformatf("bp%0d_valid", i),    32'(bus.out_valid), 32'd1);
         chk($sformatf("bp%0d_op", i),       32'(bus.operation), 32'h1);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      chk("bp_add_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_add_op",    32'(bus.operation), 32'h2);
      drive(1'b0, 2'b00, 11'd0);
      step();
      chk("drain_valid", 32'(bus.out_valid), 32'd0);

      // MUL
      drive(1'b1, 2'b10, 11'b10011011000);
      step();
      drive(1'b0, 2'b00, 11'd0);
`ifdef ALU_CTRL_MUL_EN
      chk("mul_busy1",     32'(bus.busy),      32'd1);
      chk("mul_in_ready1", 32'(bus.in_ready),  32'd0);
      chk("mul_valid1",    32'(bus.out_valid), 32'd0);
      step();
      chk("mul_busy2",     32'(bus.busy),      32'd1);
      chk("mul_in_ready2", 32'(bus.in_ready),  32'd0);
      chk("mul_valid2",    32'(bus.out_valid), 32'd0);
      step();
      chk("mul_busy3",  32'(bus.busy),       32'd0);
      chk("mul_valid",  32'(bus.out_valid),  32'd1);
      chk("mul_op",     32'(bus.operation),  32'h8);
      chk("mul_mc",     32'(bus.multicycle), 32'd1);
      chk("mul_ill",    32'(bus.illegal),    32'd0);
`else
      chk("mul_busy",  32'(bus.busy),       32'd0);
      chk("mul_valid", 32'(bus.out_valid),  32'd1);
      chk("mul_op",    32'(bus.operation),  32'h0);
      chk("mul_ill",   32'(bus.illegal),    32'd1);
      chk("mul_mc",    32'(bus.multicycle), 32'd0);
`endif
      step();
      chk("mul_drain_valid", 32'(bus.out_valid), 32'd0);

`ifdef ALU_CTRL_MUL_EN
      // Reset during the second BUSY cycle drops the MUL
      drive(1'b1, 2'b10, 11'b10011011000);
      step();
      drive(1'b0, 2'b00, 11'd0);
      chk("rbusy_busy1", 32'(bus.busy), 32'd1);
      step();
      chk("rbusy_busy2", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rbusy_valid", 32'(bus.out_valid), 32'd0);
      chk("rbusy_busy",  32'(bus.busy),      32'd0);
`else
      // Reset while a result is held drops it
      bus.out_ready = 1'b0;
      drive(1'b1, 2'b10, 11'b11001011000);
      step();
      drive(1'b0, 2'b00, 11'd0);
      chk("rvalid_pre", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rvalid_valid", 32'(bus.out_valid), 32'd0);
      chk("rvalid_op",    32'(bus.operation), 32'h0);
      bus.out_ready = 1'b1;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         step();
         chk($sformatf("post_rst%0d_valid", i), 32'(bus.out_valid), 32'd0);
         chk($sformatf("post_rst%0d_busy", i),  32'(bus.busy),      32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
